rca4bit: RTL and testbench
==========================

// Module: rca4bit
// PURPOSE
//   Registered ripple-carry adder, 4 bits by default.
//   Adds A, B and carry-in C_in through a chain of 1-bit full adders.
//   Registers sum S, carry-out C_out and a signed-overflow flag on the clock.
//   Leaf arithmetic block for datapaths that need a simple, area-minimal adder.
// PARAMETERS
//   WIDTH  4  operand and sum width in bits (legal range >= 1)
// PORTS
//   clk        input   1      single clock; all state updates on rising edge
//   rst        input   1      reset; asynchronous, active-high
//   in_valid   input   1      operands present this cycle; capture result when 1
//   C_in       input   1      carry into bit 0
//   A          input   WIDTH  operand A (unsigned or two's complement)
//   B          input   WIDTH  operand B (unsigned or two's complement)
//   S          output  WIDTH  registered sum, (A+B+C_in) mod 2^WIDTH
//   C_out      output  1      registered carry out of MSB
//   overflow   output  1      registered signed overflow (carry into MSB XOR carry out)
//   out_valid  output  1      S/C_out/overflow updated on the previous edge
// BEHAVIOUR
//   - Reset (rst=1, asynchronous, independent of clk): S=0, C_out=0, overflow=0, out_valid=0.
//     Outputs stay at these values while rst is held.
//   - Combinational: c[0]=C_in; for i in 0..WIDTH-1:
//       sum[i]=A[i]^B[i]^c[i]
//       c[i+1]=(A[i]&B[i])|((A[i]^B[i])&c[i])
//   - {C_out,S} equals the full (WIDTH+1)-bit result A+B+C_in; no saturation, wrap mod 2^WIDTH.
//   - overflow = c[WIDTH] ^ c[WIDTH-1] (two's-complement interpretation of A,B,S).
//   - Latency 1 cycle: on rising clk with in_valid=1, S/C_out/overflow load the result and out_valid=1.
//   - On rising clk with in_valid=0: S/C_out/overflow hold their previous values; out_valid=0.
//   - No backpressure; a new operand set can be accepted every cycle (throughput 1/clk).
//   - Reset asserted mid-operation discards the in-flight result.
//     First valid result after deassertion comes 1 edge after in_valid=1.
//   - Boundaries (WIDTH=4):
//     all-ones + all-ones + 1 -> S=1111, C_out=1.
//     0+0+0 -> S=0000, C_out=0.
//     1111+0000+1 -> S=0000, C_out=1 (full ripple).
//   - Outputs depend only on registers; no combinational input-to-output path.
// STRUCTURE
//   - Sub-module full_adder(A,B,C,Sum,Carry).
//     Gate level: s1=A^B, Sum=s1^C, Carry=(A&B)|(s1&C).
//     Instantiated WIDTH times in a generate loop; carry chains LSB->MSB.
//   - Output register stage in rca4bit, in an always block sensitive to posedge clk / posedge rst.
//   - Shared package: no typedefs required.
//     The default width constant ADDER_W=4 lives in the common arithmetic package.
//     WIDTH defaults to it.
// TESTING
//   1. rst=1 with random A/B/in_valid
//      -> S=0000, C_out=0, overflow=0, out_valid=0, with and without clk edges.
//   2. C_in=0, in_valid=1: A=0110, B=1100
//      -> next edge S=0010, C_out=1, overflow=0, out_valid=1.
//   3. Back-to-back, one per cycle:
//      - 1110+1000 -> S=0110, C_out=1, ovf=1
//      - 0111+1110 -> S=0101, C_out=1, ovf=0
//      - 0010+1001 -> S=1011, C_out=0, ovf=0
//   4. Full ripple: A=1111, B=0000, C_in=1 -> S=0000, C_out=1.
//      Signed overflow: A=0111, B=0001, C_in=0 -> S=1000, C_out=0, overflow=1.
//   5. in_valid=0 for 3 cycles with changing A/B -> S/C_out hold last value, out_valid=0.
//   6. Assert rst between edges while in_valid=1 -> outputs clear immediately.
//      Exhaustive 2^9 sweep after release matches {C_out,S}=A+B+C_in.

Source files
------------

// File: rtl/rca4bit_pkg.sv
// rtl/rca4bit_pkg.sv - shared arithmetic constants for the adder datapath
package rca4bit_pkg;

  localparam int ADDER_W = 4;

endpackage

// File: rtl/rca4bit_full_adder.sv
// rtl/rca4bit_full_adder.sv - gate-level 1-bit full adder, one ripple stage
module rca4bit_full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);

  logic s1;

  assign s1    = A ^ B;
  assign Sum   = s1 ^ C;
  assign Carry = (A & B) | (s1 & C);

endmodule

// File: rtl/rca4bit.sv
// rtl/rca4bit.sv - registered ripple-carry adder with carry-out and signed overflow
module rca4bit
  import rca4bit_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             C_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign carry[0] = C_in;

  // Carry ripples LSB to MSB through one full adder per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    rca4bit_full_adder u_fa (
      .A     (A[i]),
      .B     (B[i]),
      .C     (carry[i]),
      .Sum   (sum[i]),
      .Carry (carry[i+1])
    );
  end

  always_comb begin
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d     = sum;
      c_out_d = carry[WIDTH];
      ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign C_out     = c_out_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rca4bit.sv
// tb/tb_rca4bit.sv - randomized self-checking bench for rca4bit against an arithmetic model
module tb_rca4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       C_in = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] S;
  logic       C_out;
  logic       overflow;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_s = 4'd0;
  logic       exp_c = 1'b0;
  logic       exp_o = 1'b0;
  logic       exp_v = 1'b0;

  rca4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .C_in      (C_in),
    .A         (A),
    .B         (B),
    .S         (S),
    .C_out     (C_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: integer sum for S/C_out, signed range test for overflow.
  function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic c);
    int full, sa, sb, ss;
    logic [4:0] f;
    logic ov;
    full = int'(a) + int'(b) + int'(c);
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    ss = sa + sb + int'(c);
    ov = (ss > 7) || (ss < -8);
    f = full[4:0];
    return {ov, f};
  endfunction

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    logic [5:0] r;
    @(negedge clk);
    A = a; B = b; C_in = c; in_valid = v;
    @(posedge clk);
    r = ref_add(a, b, c);
    exp_v = v;
    if (v) begin
      exp_s = r[3:0];
      exp_c = r[4];
      exp_o = r[5];
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    A = 4'($urandom); B = 4'($urandom); in_valid = 1'($urandom); C_in = 1'($urandom);
    rst = 1'b1;
    #1;
    checks++;
    if ({S, C_out, overflow, out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async got S=%b C=%b O=%b V=%b want all zero", S, C_out, overflow, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = 4'($urandom); B = 4'($urandom); in_valid = 1'($urandom); C_in = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({S, C_out, overflow, out_valid} !== 7'd0) begin
        errors++;
        $display("FAIL reset_held got S=%b C=%b O=%b V=%b want all zero", S, C_out, overflow, out_valid);
      end
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    exp_s = 4'd0; exp_c = 1'b0; exp_o = 1'b0; exp_v = 1'b0;
  endtask

  task automatic test_basic();
    step(4'b0110, 4'b1100, 1'b0, 1'b1);
    checks++;
    if ({S, C_out, overflow, out_valid} !== {4'b0010, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic got S=%b C=%b O=%b V=%b want S=0010 C=1 O=0 V=1", S, C_out, overflow, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [3] = '{4'b1110, 4'b0111, 4'b0010};
    logic [3:0] tb [3] = '{4'b1000, 4'b1110, 4'b1001};
    logic [6:0] want [3] = '{{4'b0110, 1'b1, 1'b1, 1'b1},
                              {4'b0101, 1'b1, 1'b0, 1'b1},
                              {4'b1011, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      step(ta[i], tb[i], 1'b0, 1'b1);
      checks++;
      if ({S, C_out, overflow, out_valid} !== want[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %b want %b", i, {S, C_out, overflow, out_valid}, want[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] ta [4] = '{4'b1111, 4'b0111, 4'b1111, 4'b0000};
    logic [3:0] tb [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b0000};
    logic       tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] want [4] = '{{4'b0000, 1'b1, 1'b0, 1'b1},
                              {4'b1000, 1'b0, 1'b1, 1'b1},
                              {4'b1111, 1'b1, 1'b0, 1'b1},
                              {4'b0000, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      step(ta[i], tb[i], tc[i], 1'b1);
      checks++;
      if ({S, C_out, overflow, out_valid} !== want[i]) begin
        errors++;
        $display("FAIL boundary[%0d] got %b want %b", i, {S, C_out, overflow, out_valid}, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(4'b0111, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      checks++;
      if ({S, C_out, overflow, out_valid} !== {4'b1000, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d] got %b want 1000010", i, {S, C_out, overflow, out_valid});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      checks++;
      if ({S, C_out, overflow, out_valid} !== {exp_s, exp_c, exp_o, exp_v}) begin
        errors++;
        $display("FAIL random[%0d] got %b want %b", i, {S, C_out, overflow, out_valid},
                 {exp_s, exp_c, exp_o, exp_v});
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(4'b0101, 4'b0101, 1'b1, 1'b1);
    @(negedge clk);
    A = 4'b1111; B = 4'b1111; C_in = 1'b1; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({S, C_out, overflow, out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL midflight_clear got %b want 0000000", {S, C_out, overflow, out_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({S, C_out, overflow, out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL midflight_discard got %b want 0000000", {S, C_out, overflow, out_valid});
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    exp_s = 4'd0; exp_c = 1'b0; exp_o = 1'b0; exp_v = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({S, C_out, overflow, out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL after_release got %b want 0000000", {S, C_out, overflow, out_valid});
    end
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    logic [4:0] total;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      step(v[3:0], v[7:4], v[8], 1'b1);
      total = 5'(int'(v[3:0]) + int'(v[7:4]) + int'(v[8]));
      checks++;
      if ({C_out, S, overflow, out_valid} !== {total, exp_o, 1'b1}) begin
        errors++;
        $display("FAIL sweep a=%b b=%b c=%b got C=%b S=%b O=%b V=%b want C/S=%b O=%b",
                 v[3:0], v[7:4], v[8], C_out, S, overflow, out_valid, total, exp_o);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_hold();
    test_random();
    test_reset_midflight();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
